// File: rtl/aes128_iter_core_if.sv
// Handshake bundle between the block-mode front end, the AES core and the ciphertext sink.
// The master side drives plaintext/key and out_ready; the slave (core) side answers.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE cascaded rounds per clock with on-the-fly
// key expansion, valid/ready on input and output.
module aes128_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    aes128_iter_core_if.slave bus
);
    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_unroll
            $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2 or 5");
        end
    endgenerate

    localparam logic [3:0] U4 = 4'(ROUNDS_PER_CYCLE);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic [127:0] out_data_q;
    logic [127:0] st_c [ROUNDS_PER_CYCLE+1];
    logic [127:0] rk_c [ROUNDS_PER_CYCLE+1];
    logic         last_step;
    logic         accept;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte b lives at bits [127-8b -: 8]; row = b%4, column = b/4, row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[127 - 8*(row + 4*col) -: 8] = s[127 - 8*(row + 4*((col + row) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Unrolled rounds chain combinationally; round 10 drops MixColumns.
    always_comb begin
        st_c[0] = st;
        rk_c[0] = rk;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            rk_c[i+1] = key_expand(rk_c[i], rcon(rnd + 4'(i)));
            if (rnd + 4'(i) == 4'd10)
                st_c[i+1] = shift_rows(sub_bytes(st_c[i])) ^ rk_c[i+1];
            else
                st_c[i+1] = mix_columns(shift_rows(sub_bytes(st_c[i]))) ^ rk_c[i+1];
        end
    end

    assign last_step     = (rnd + U4 - 4'd1) == 4'd10;
    assign bus.in_ready  = ((state == IDLE) || (state == DONE && bus.out_ready)) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN);
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            st         <= '0;
            rk         <= '0;
            rnd        <= '0;
            out_data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        st    <= bus.in_data ^ bus.in_key;
                        rk    <= bus.in_key;
                        rnd   <= 4'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    st  <= st_c[ROUNDS_PER_CYCLE];
                    rk  <= rk_c[ROUNDS_PER_CYCLE];
                    rnd <= rnd + U4;
                    if (last_step) begin
                        out_data_q <= st_c[ROUNDS_PER_CYCLE];
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            st    <= bus.in_data ^ bus.in_key;
                            rk    <= bus.in_key;
                            rnd   <= 4'd1;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: FIPS-197 vectors through a scoreboard, latency,
// back-to-back, backpressure, ignored input and mid-run reset; U=2 and U=5 instances too.
module tb_aes128_iter_core;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;

    aes128_iter_core_if m ();
    aes128_iter_core_if m2 ();
    aes128_iter_core_if m5 ();

    aes128_iter_core #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(m));
    aes128_iter_core #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(m2));
    aes128_iter_core #(.ROUNDS_PER_CYCLE(5)) dut5 (.clk(clk), .rst(rst), .bus(m5));

    always #5 clk = ~clk;

    logic [127:0] exp_q[$];
    logic [127:0] cur_exp = '0;
    logic         ov_prev = 1'b0;
    int cyc = 0, acc_cyc = 0, hs_cyc = 0, rise_cyc = 0;
    int acc_n = 0, out_n = 0, rise_n = 0, run_rdy_err = 0;
    int assert_count = 0, fail_count = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] key, input logic [127:0] exp);
        m.in_data  = data;
        m.in_key   = key;
        m.in_valid = 1'b1;
        cur_exp    = exp;
    endtask

    task automatic waitRises(input int target, input string tag);
        int k = 0;
        while (rise_n < target && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 128'(rise_n >= target), 128'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sampled 1 ns before each rising edge: what the upcoming edge will act on.
    always @(negedge clk) begin
        #4;
        if (!rst && m.in_valid && m.in_ready) begin
            exp_q.push_back(cur_exp);
            acc_cyc = cyc + 1;
            acc_n++;
        end
        if (!rst && m.out_valid && m.out_ready) begin
            checkOutput("sb_pending", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) checkOutput("sb_data", m.out_data, exp_q.pop_front());
            hs_cyc = cyc + 1;
            out_n++;
        end
        if (m.out_valid && !ov_prev) begin
            rise_cyc = cyc;
            rise_n++;
        end
        ov_prev = m.out_valid;
        if (m.busy && m.in_ready) run_rdy_err++;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bp_err;
        int r1;
        int rn;
        int lat2;
        int lat5;
        logic [127:0] d2;
        logic [127:0] d5;

        rst = 1'b1;
        m.in_valid  = 1'b0;  m.in_data  = '0; m.in_key  = '0; m.out_ready  = 1'b0;
        m2.in_valid = 1'b0;  m2.in_data = '0; m2.in_key = '0; m2.out_ready = 1'b1;
        m5.in_valid = 1'b0;  m5.in_data = '0; m5.in_key = '0; m5.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", m.in_ready, 0);
        checkOutput("rst_out_valid", m.out_valid, 0);
        checkOutput("rst_busy", m.busy, 0);
        checkOutput("rst_out_data", m.out_data, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", m.in_ready, 1);

        // App. B with garbage on the input side during RUN, then held under backpressure
        @(negedge clk);
        applyStimulus(B_PT, B_KEY, B_CT);
        @(negedge clk);
        checkOutput("busy_after_accept", m.busy, 1);
        for (int i = 0; i < 9; i++) begin
            m.in_valid = 1'($urandom_range(0, 1));
            m.in_data  = {$urandom, $urandom, $urandom, $urandom};
            m.in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        waitRises(1, "wait_b");
        checkOutput("latency_u1_b", rise_cyc - acc_cyc, 10);
        applyStimulus(C_PT, C_KEY, C_CT);
        bp_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m.out_valid !== 1'b1 || m.out_data !== B_CT || m.in_ready !== 1'b0) bp_err++;
        end
        checkOutput("bp_hold_errs", bp_err, 0);
        checkOutput("bp_out_data", m.out_data, B_CT);
        checkOutput("bp_no_accept", acc_n, 1);
        m.out_ready = 1'b1;
        @(negedge clk);
        m.in_valid = 1'b0;
        checkOutput("bp_release_accept", acc_n, 2);
        waitRises(2, "wait_c_after_bp");
        checkOutput("latency_u1_c", rise_cyc - acc_cyc, 10);
        repeat (2) @(negedge clk);

        // Back-to-back with in_valid held and out_ready high
        applyStimulus(B_PT, B_KEY, B_CT);
        @(negedge clk);
        applyStimulus(C_PT, C_KEY, C_CT);
        waitRises(3, "wait_b2b_first");
        r1 = rise_cyc;
        for (int i = 0; i < 10 && acc_n < 4; i++) @(negedge clk);
        m.in_valid = 1'b0;
        checkOutput("b2b_accept_count", acc_n, 4);
        checkOutput("b2b_same_edge", acc_cyc, hs_cyc);
        waitRises(4, "wait_b2b_second");
        checkOutput("b2b_spacing", rise_cyc - r1, 11);
        repeat (2) @(negedge clk);

        // Reset while round 4 is pending
        applyStimulus(C_PT, C_KEY, C_CT);
        @(negedge clk);
        m.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", m.out_valid, 0);
        checkOutput("midrst_busy", m.busy, 0);
        checkOutput("midrst_in_ready", m.in_ready, 0);
        checkOutput("midrst_out_data", m.out_data, 0);
        exp_q.delete();
        rn = rise_n;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("midrst_no_out_valid", rise_n, rn);
        applyStimulus(C_PT, C_KEY, C_CT);
        @(negedge clk);
        m.in_valid = 1'b0;
        waitRises(rn + 1, "wait_after_rst");
        checkOutput("latency_after_rst", rise_cyc - acc_cyc, 10);
        repeat (2) @(negedge clk);

        // Unrolled instances, same App. C.1 block
        checkOutput("u2_in_ready", m2.in_ready, 1);
        checkOutput("u5_in_ready", m5.in_ready, 1);
        m2.in_data = C_PT; m2.in_key = C_KEY; m2.in_valid = 1'b1;
        m5.in_data = C_PT; m5.in_key = C_KEY; m5.in_valid = 1'b1;
        @(negedge clk);
        m2.in_valid = 1'b0;
        m5.in_valid = 1'b0;
        lat2 = 0; lat5 = 0; d2 = '0; d5 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (m2.out_valid && lat2 == 0) begin lat2 = k; d2 = m2.out_data; end
            if (m5.out_valid && lat5 == 0) begin lat5 = k; d5 = m5.out_data; end
        end
        checkOutput("latency_u2", lat2, 5);
        checkOutput("latency_u5", lat5, 2);
        checkOutput("data_u2", d2, C_CT);
        checkOutput("data_u5", d5, C_CT);

        @(negedge clk);
        checkOutput("sb_empty", exp_q.size(), 0);
        checkOutput("out_handshakes", out_n, 5);
        checkOutput("run_ready_errs", run_rdy_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
